// File: rtl/ioctl_upload_server_if.sv
// rtl/ioctl_upload_server_if.sv - hps_io upload request and game-RAM read port bundle
interface ioctl_upload_server_if #(
  parameter int MEM_AW = 16
);
  logic              ioctl_upload;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              mem_rd;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_q;

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, mem_ack, mem_q,
    input  ioctl_din, ioctl_wait, mem_rd, mem_addr
  );

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, mem_ack, mem_q,
    output ioctl_din, ioctl_wait, mem_rd, mem_addr
  );
endinterface

// File: rtl/ioctl_upload_server.sv
// rtl/ioctl_upload_server.sv - serves HPS upload byte reads from game RAM plus a trailing checksum byte
module ioctl_upload_server #(
  parameter int          DATA_LEN  = 256,
  parameter int          MEM_AW    = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          TIMEOUT   = 1023
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  ioctl_upload_server_if.slave  bus,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int                TW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [24:0]       LEN25  = 25'(DATA_LEN);
  localparam logic [MEM_AW-1:0] BASE   = MEM_AW'(BASE_ADDR);
  localparam logic [TW-1:0]     TO_MAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_FETCH
  } state_t;

  state_t            state, state_d;
  logic              upload_q;
  logic [7:0]        din_r, din_d;
  logic              wait_r, wait_d;
  logic              rd_r, rd_d;
  logic [MEM_AW-1:0] addr_r, addr_d;
  logic [7:0]        csum, csum_d;
  logic [TW-1:0]     timer, timer_d;
  logic              terr, terr_d;
  logic              upload_rise;

  assign upload_rise = bus.ioctl_upload & ~upload_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= S_IDLE;
      upload_q <= 1'b0;
      din_r    <= 8'h00;
      wait_r   <= 1'b0;
      rd_r     <= 1'b0;
      addr_r   <= '0;
      csum     <= 8'h00;
      timer    <= '0;
      terr     <= 1'b0;
    end else begin
      state    <= state_d;
      upload_q <= bus.ioctl_upload;
      din_r    <= din_d;
      wait_r   <= wait_d;
      rd_r     <= rd_d;
      addr_r   <= addr_d;
      csum     <= csum_d;
      timer    <= timer_d;
      terr     <= terr_d;
    end
  end

  always_comb begin
    state_d = state;
    din_d   = din_r;
    wait_d  = wait_r;
    rd_d    = rd_r;
    addr_d  = addr_r;
    csum_d  = csum;
    timer_d = timer;
    terr_d  = terr;

    // Session end wins over everything; din keeps the last served byte.
    if (state != S_IDLE && !bus.ioctl_upload) begin
      state_d = S_IDLE;
      rd_d    = 1'b0;
      wait_d  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (upload_rise) begin
            csum_d  = 8'h00;
            terr_d  = 1'b0;
            state_d = S_ARMED;
          end
        end

        S_ARMED: begin
          if (bus.ioctl_rd) begin
            if (bus.ioctl_addr < LEN25) begin
              wait_d  = 1'b1;
              rd_d    = 1'b1;
              addr_d  = BASE + bus.ioctl_addr[MEM_AW-1:0];
              timer_d = '0;
              state_d = S_FETCH;
            end else if (bus.ioctl_addr == LEN25) begin
              din_d = (~csum) + 8'd1;
            end else begin
              din_d = 8'hFF;
            end
          end
        end

        S_FETCH: begin
          // A stray ioctl_rd here is a host protocol error and is ignored.
          if (bus.mem_ack) begin
            din_d   = bus.mem_q;
            csum_d  = csum + bus.mem_q;
            rd_d    = 1'b0;
            wait_d  = 1'b0;
            state_d = S_ARMED;
          end else if (timer == TO_MAX) begin
            din_d   = 8'hFF;
            csum_d  = csum + 8'hFF;
            terr_d  = 1'b1;
            rd_d    = 1'b0;
            wait_d  = 1'b0;
            state_d = S_ARMED;
          end else begin
            timer_d = timer + TW'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
          rd_d    = 1'b0;
          wait_d  = 1'b0;
        end
      endcase
    end
  end

  assign bus.ioctl_din  = din_r;
  assign bus.ioctl_wait = wait_r;
  assign bus.mem_rd     = rd_r;
  assign bus.mem_addr   = addr_r;
  assign busy           = (state != S_IDLE);
  assign timeout_err    = terr;

endmodule
